// File: rtl/spi_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_cmd_rx
// Purpose  : SPI mode-0 slave byte receiver feeding a show-ahead byte FIFO.
//            Optional status byte on MISO when SPI_CMD_RX_STATUS_MISO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_rx #(
    parameter int FIFO_DEPTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          next,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          frame_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   flush;
    logic                   sck_d;
    logic                   cs_d;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [7:0]             mem [FIFO_DEPTH];

    logic          sck_s, cs_n_s, mosi_s;
    logic          sck_rise, sck_fall, cs_rise, cs_fall, active;
    logic          capture, pop, push_ok, drop;
    logic [7:0]    byte_in;
    logic [CW-1:0] count_next;
    logic          overflow_next;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // flush tracks when the chains hold real pin samples rather than reset values,
    // so a frame already running at reset release is not mistaken for a new one.
    assign active   = armed && !cs_n_s;
    assign sck_rise = sck_s && !sck_d;
    assign sck_fall = !sck_s && sck_d;
    assign cs_rise  = cs_n_s && !cs_d;
    assign cs_fall  = !cs_n_s && cs_d && armed;
    assign capture  = sck_rise && active && (bit_cnt == 3'd7);
    assign byte_in  = {shreg, mosi_s};

    always_comb begin
        pop           = next && out_valid;
        push_ok       = capture && ((count < DEPTH_C) || pop);
        drop          = capture && !push_ok;
        count_next    = count + CW'(push_ok) - CW'(pop);
        overflow_next = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            flush     <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_n_s;
            if (flush[SYNC_STAGES] && cs_n_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (cs_rise) begin
                if (bit_cnt != 3'd0)
                    frame_error <= 1'b1;
                bit_cnt <= 3'd0;
                shreg   <= 7'd0;
            end else if (sck_rise && active) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            overflow <= overflow_next;
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= byte_in;
    end

    assign out_byte   = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign fifo_level = count;

`ifdef SPI_CMD_RX_STATUS_MISO_EN
    logic [7:0]    miso_sr;
    logic [CW-1:0] free_c;
    logic [5:0]    free6;
    logic [7:0]    status;

    // Status reflects the state the FIFO will hold after this edge.
    always_comb begin
        free_c = DEPTH_C - count_next;
        free6  = (int'(free_c) > 63) ? 6'd63 : 6'(free_c);
        status = {overflow_next, (count_next == DEPTH_C), free6};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miso_sr <= 8'd0;
        else if (cs_fall || capture)
            miso_sr <= status;
        else if (sck_fall && active)
            miso_sr <= {miso_sr[6:0], 1'b0};
    end

    assign spi_miso = active ? miso_sr[7] : 1'b0;
`else
    logic unused_status;
    assign unused_status = cs_fall ^ sck_fall;
    assign spi_miso      = 1'b0;
`endif

endmodule
`default_nettype wire
